// File: rtl/reg_file_pkg.sv
// Shared constants and word type for the register file.
// Instances may override the widths, but these are the defaults everywhere.
package reg_file_pkg;
    localparam int DEFAULT_LENGTH = 8;
    localparam int DEFAULT_NREGS  = 8;

    typedef logic [DEFAULT_LENGTH-1:0] word_t;
endpackage

// File: rtl/reg_file.sv
// Register file: NREGS x LENGTH registers, one write port and two combinational read ports.
// Asynchronous active-low reset clears every register.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int LENGTH   = DEFAULT_LENGTH,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int SEL_BITS = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [SEL_BITS-1:0] addr_d,
    input  logic [LENGTH-1:0]   data_in,
    input  logic [SEL_BITS-1:0] addr_a,
    input  logic [SEL_BITS-1:0] addr_b,
    output logic [LENGTH-1:0]   data_out_a,
    output logic [LENGTH-1:0]   data_out_b
);

    logic [LENGTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  w_wr_en;
    logic [LENGTH-1:0] w_rd_a;
    logic [LENGTH-1:0] w_rd_b;

    // Decoding against every legal index means unused codes (non-power-of-two NREGS) select nothing.
    always_comb begin
        w_wr_en = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_wr_en[i] = wr && (addr_d == SEL_BITS'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_en[i]) begin
                    r_regs[i] <= data_in;
                end
            end
        end
    end

    // Read muxes default to zero so out-of-range indices read as 0; no bypass from data_in.
    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (addr_a == SEL_BITS'(i)) begin
                w_rd_a = r_regs[i];
            end
            if (addr_b == SEL_BITS'(i)) begin
                w_rd_b = r_regs[i];
            end
        end
    end

    assign data_out_a = w_rd_a;
    assign data_out_b = w_rd_b;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, multi-cycle corner sequences,
// and randomized traffic against an array model (default 8-reg instance plus a 6-reg instance).
module tb_reg_file;
    import reg_file_pkg::*;

    logic        clk;
    logic        reset;
    logic        wr;
    logic [2:0]  addr_d, addr_a, addr_b;
    word_t       data_in;
    word_t       data_out_a, data_out_b;

    logic        wr6;
    logic [2:0]  ad6, aa6, ab6;
    word_t       din6;
    word_t       dout6_a, dout6_b;

    int n_tests = 0;
    int n_fail  = 0;

    word_t m8 [8];
    word_t m6 [6];

    reg_file #(.LENGTH(8), .NREGS(8)) dut (
        .clk(clk), .reset(reset), .wr(wr), .addr_d(addr_d), .data_in(data_in),
        .addr_a(addr_a), .addr_b(addr_b), .data_out_a(data_out_a), .data_out_b(data_out_b)
    );

    reg_file #(.LENGTH(8), .NREGS(6)) dut6 (
        .clk(clk), .reset(reset), .wr(wr6), .addr_d(ad6), .data_in(din6),
        .addr_a(aa6), .addr_b(ab6), .data_out_a(dout6_a), .data_out_b(dout6_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string      name;
        bit         wr;
        logic [2:0] ad;
        word_t      din;
        logic [2:0] aa;
        logic [2:0] ab;
        word_t      ea;
        word_t      eb;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input word_t act, input word_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic word_t ref6(input logic [2:0] a);
        return (a < 3'd6) ? m6[a] : 8'h00;
    endfunction

    // Model updates from the inputs present at the rising edge, then sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (reset && wr) m8[addr_d] = data_in;
        if (reset && wr6 && ad6 < 3'd6) m6[ad6] = din6;
        #1;
    endtask

    task automatic sweep8(input string name);
        for (int i = 0; i < 8; i++) begin
            addr_a = 3'(i);
            addr_b = 3'(7 - i);
            #1;
            check({name, "_a"}, data_out_a, m8[i]);
            check({name, "_b"}, data_out_b, m8[7 - i]);
        end
    endtask

    initial begin
        reset = 1'b0; wr = 1'b0; addr_d = '0; data_in = '0; addr_a = '0; addr_b = 3'd7;
        wr6 = 1'b0; ad6 = '0; din6 = '0; aa6 = '0; ab6 = '0;
        for (int i = 0; i < 8; i++) m8[i] = '0;
        for (int i = 0; i < 6; i++) m6[i] = '0;

        #12;
        check("reset_state_a", data_out_a, 8'h00);
        check("reset_state_b", data_out_b, 8'h00);
        check("reset_state6_a", dout6_a, 8'h00);
        reset = 1'b1;

        vecs[0] = '{"write0_AA",    1'b1, 3'd0, 8'hAA, 3'd0, 3'd3, 8'hAA, 8'h00};
        vecs[1] = '{"overwrite0",   1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'hFF, 8'h00};
        vecs[2] = '{"nowrite3",     1'b0, 3'd3, 8'h55, 3'd3, 3'd0, 8'h00, 8'hFF};
        vecs[3] = '{"write2_11",    1'b1, 3'd2, 8'h11, 3'd2, 3'd0, 8'h11, 8'hFF};
        vecs[4] = '{"dual_read",    1'b1, 3'd5, 8'h22, 3'd2, 3'd5, 8'h11, 8'h22};
        vecs[5] = '{"dual_swap",    1'b0, 3'd5, 8'h99, 3'd5, 3'd2, 8'h22, 8'h11};
        vecs[6] = '{"same_addr",    1'b1, 3'd7, 8'hC3, 3'd7, 3'd7, 8'hC3, 8'hC3};

        for (int v = 0; v < 7; v++) begin
            wr = vecs[v].wr; addr_d = vecs[v].ad; data_in = vecs[v].din;
            addr_a = vecs[v].aa; addr_b = vecs[v].ab;
            tick();
            check({vecs[v].name, "_a"}, data_out_a, vecs[v].ea);
            check({vecs[v].name, "_b"}, data_out_b, vecs[v].eb);
        end

        // Read-during-write: old value before the edge, new value after it.
        wr = 1'b1; addr_d = 3'd4; data_in = 8'h10; addr_a = 3'd4;
        tick();
        data_in = 8'h20;
        @(negedge clk);
        check("rdw_before_edge", data_out_a, 8'h10);
        tick();
        check("rdw_after_edge", data_out_a, 8'h20);

        // Four edges with wr=0 and changing address/data must leave everything alone.
        wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            addr_d = 3'(k + 1);
            data_in = 8'h5A ^ 8'(k * 37);
            tick();
        end
        sweep8("hold");

        // Back-to-back writes on consecutive edges each land.
        wr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr_d = 3'(k + 1);
            data_in = 8'(8'h31 + k);
            tick();
        end
        wr = 1'b0;
        addr_a = 3'd1; addr_b = 3'd3; #1;
        check("b2b_reg1", data_out_a, 8'h31);
        check("b2b_reg3", data_out_b, 8'h33);
        addr_a = 3'd2; #1;
        check("b2b_reg2", data_out_a, 8'h32);

        // Mid-cycle reset with a write pending: clears immediately, write is lost.
        addr_a = 3'd0; addr_b = 3'd7;
        @(posedge clk); #4;
        wr = 1'b1; addr_d = 3'd1; data_in = 8'h77;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m8[i] = '0;
        for (int i = 0; i < 6; i++) m6[i] = '0;
        #1;
        check("rst_async_a", data_out_a, 8'h00);
        check("rst_async_b", data_out_b, 8'h00);
        #8;
        addr_a = 3'd1; #0;
        check("rst_held_a", data_out_a, 8'h00);
        check("rst_held_b", data_out_b, 8'h00);
        #1;
        reset = 1'b1;
        wr = 1'b0;
        sweep8("after_reset");
        wr = 1'b1; addr_d = 3'd1; data_in = 8'h5A; addr_a = 3'd1;
        tick();
        check("first_write_after_reset", data_out_a, 8'h5A);
        wr = 1'b0;

        // 6-register instance: indices 6 and 7 ignore writes and read as zero.
        wr6 = 1'b1; ad6 = 3'd6; din6 = 8'hE6; aa6 = 3'd6; ab6 = 3'd0;
        tick();
        check("oor_write6", dout6_a, 8'h00);
        check("oor_alias0", dout6_b, 8'h00);
        ad6 = 3'd5; din6 = 8'hB5; aa6 = 3'd5; ab6 = 3'd7;
        tick();
        check("inrange_write5", dout6_a, 8'hB5);
        check("oor_read7", dout6_b, 8'h00);
        wr6 = 1'b0;

        // Randomized traffic on both instances against the array model.
        for (int it = 0; it < 300; it++) begin
            wr = 1'($urandom_range(0, 1)); addr_d = 3'($urandom); data_in = 8'($urandom);
            addr_a = 3'($urandom); addr_b = 3'($urandom);
            wr6 = 1'($urandom_range(0, 1)); ad6 = 3'($urandom); din6 = 8'($urandom);
            aa6 = 3'($urandom); ab6 = 3'($urandom);
            tick();
            check("rand8_a", data_out_a, m8[addr_a]);
            check("rand8_b", data_out_b, m8[addr_b]);
            check("rand6_a", dout6_a, ref6(aa6));
            check("rand6_b", dout6_b, ref6(ab6));
        end
        wr = 1'b0; wr6 = 1'b0;
        sweep8("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter LENGTH, default 8: bit width of every register and data port.
REQ-002 Parameter NREGS, default 8: number of registers, legal range 2..256.
REQ-003 Parameter SEL_BITS, default $clog2(NREGS): address width, derived and not overridden.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 wr  input  1  write enable, sampled on rising clk edge.
REQ-007 addr_d  input  SEL_BITS  write (destination) register index.
REQ-008 data_in  input  LENGTH  write data.
REQ-009 addr_a  input  SEL_BITS  read port A register index.
REQ-010 addr_b  input  SEL_BITS  read port B register index.
REQ-011 data_out_a  output  LENGTH  contents of register addr_a.
REQ-012 data_out_b  output  LENGTH  contents of register addr_b.

Function
REQ-013 The block SHALL hold NREGS registers of LENGTH bits; all registers, including index 0, are writable.
REQ-014 On a rising clk edge with reset high and wr=1, register[addr_d] SHALL load data_in; all other registers hold.
REQ-015 With wr=0, no register SHALL change.
REQ-016 Read ports SHALL be combinational: data_out_a = register[addr_a], data_out_b = register[addr_b], zero-cycle latency from an address change.
REQ-017 Ports A and B SHALL be independent; equal addresses return identical data.
REQ-018 Read-during-write to the same index SHALL return the old value until the write edge, then the new value in the same cycle after the edge (no bypass from data_in).
REQ-019 Indices >= NREGS (non-power-of-two NREGS) SHALL read as 0, and writes to them SHALL be ignored.
REQ-020 Writes SHALL be write-once per edge; consecutive edges with wr=1 each perform a write.

Reset
REQ-021 reset=0 SHALL clear every register to 0 immediately, independent of clk.
REQ-022 While reset=0, writes SHALL be suppressed and both outputs SHALL read 0.
REQ-023 A write coinciding with reset assertion SHALL be lost; after release, the first rising edge with wr=1 writes normally.
REQ-024 Reset deassertion SHALL be synchronised by the surrounding system; the block needs no internal synchroniser.

Structure
REQ-025 A shared package reg_file_pkg SHALL hold the default LENGTH and NREGS constants and a data-word typedef.
REQ-026 The block SHALL be a single module containing the register array, write decoder and two read multiplexers; no sub-module is required.

Verification
REQ-027 Reset: load non-zero data, pulse reset low for 10 ns mid-cycle -> both outputs 0 immediately; all 8 registers read 0.
REQ-028 Write/read: addr_d=0, data_in=0xAA, wr=1 for one edge, addr_a=0 -> data_out_a=0xAA; addr_a=3 -> 0x00.
REQ-029 Overwrite: addr_d=0, data_in=0xFF, wr=1 for one edge -> data_out_a (addr_a=0)=0xFF; then set addr_d=3 with wr=0 -> register 3 still 0x00.
REQ-030 Dual read: write 0x11 to reg 2 and 0x22 to reg 5; addr_a=2, addr_b=5 -> 0x11/0x22; swap addresses -> 0x22/0x11.
REQ-031 Read-during-write: addr_a=addr_d=4, reg4=0x10, data_in=0x20, wr=1 -> data_out_a=0x10 before the edge, 0x20 after.
REQ-032 wr=0 hold: change data_in and addr_d over 4 edges with wr=0 -> all registers unchanged.
